// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain pad enables.
// Optional device-response timeout is built when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int CLK_KHZ         = 24000,
  parameter int INHIBIT_US      = 120,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int TIMEOUT_MS      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  output logic       kbd_clk_oe,
  output logic       kbd_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);

  localparam int INH_CYCLES = CLK_KHZ * INHIBIT_US / 1000;
  localparam int INH_W      = $clog2(INH_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INH_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_START = INH_W'(INH_CYCLES - 2);
  localparam int DEB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_CYCLES = CLK_KHZ * TIMEOUT_MS;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_r;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RELEASE   = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t           state_r;
  logic [1:0]       clk_sync_r;
  logic [1:0]       data_sync_r;
  logic             clk_deb_r;
  logic             clk_deb_prev_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic [9:0]       shreg_r;
  logic [3:0]       bitcnt_r;
  logic [INH_W-1:0] inh_cnt_r;
  logic             ack_ok_r;
  logic             clk_s;
  logic             data_s;
  logic             fall_s;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  assign clk_s  = clk_sync_r[1];
  assign data_s = data_sync_r[1];
  assign fall_s = clk_deb_prev_r & ~clk_deb_r;

  // Two-flop synchronisers for the raw pad inputs; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], kbd_clk};
      data_sync_r <= {data_sync_r[0], kbd_data};
    end
  end

  // Clock debounce: a new level is taken only after it persists for DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_deb_r      <= 1'b1;
      clk_deb_prev_r <= 1'b1;
      deb_cnt_r      <= '0;
    end else begin
      clk_deb_prev_r <= clk_deb_r;
      if (clk_s == clk_deb_r) begin
        deb_cnt_r <= '0;
      end else if (deb_cnt_r == DEB_LAST) begin
        clk_deb_r <= clk_s;
        deb_cnt_r <= '0;
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end
    end
  end

  // Transmit sequencer; every output is a register so the pads never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      kbd_clk_oe  <= 1'b0;
      kbd_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      rx_inhibit  <= 1'b0;
      shreg_r     <= 10'd0;
      bitcnt_r    <= 4'd0;
      inh_cnt_r   <= '0;
      ack_ok_r    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_r    <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state_r)
        S_IDLE: begin
          kbd_clk_oe  <= 1'b0;
          kbd_data_oe <= 1'b0;
          tx_ready    <= 1'b1;
          rx_inhibit  <= 1'b0;
          if (tx_valid && tx_ready) begin
            shreg_r    <= {1'b1, odd_parity(tx_data), tx_data};
            bitcnt_r   <= 4'd0;
            inh_cnt_r  <= '0;
            kbd_clk_oe <= 1'b1;
            tx_ready   <= 1'b0;
            rx_inhibit <= 1'b1;
            state_r    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          inh_cnt_r <= inh_cnt_r + INH_W'(1);
          // Start bit goes onto the bus in the final inhibit cycle.
          if (inh_cnt_r == INH_START) begin
            kbd_data_oe <= 1'b1;
          end
          if (inh_cnt_r == INH_LAST) begin
            kbd_clk_oe <= 1'b0;
            state_r    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          kbd_clk_oe <= 1'b0;
          state_r    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (fall_s) begin
            kbd_data_oe <= ~shreg_r[0];
            shreg_r     <= {1'b1, shreg_r[9:1]};
            bitcnt_r    <= bitcnt_r + 4'd1;
            if (bitcnt_r == 4'd9) begin
              state_r <= S_ACK;
            end
          end
        end
        S_ACK: begin
          kbd_data_oe <= 1'b0;
          if (fall_s) begin
            ack_ok_r <= ~data_s;
            state_r  <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          kbd_data_oe <= 1'b0;
          if (clk_deb_r && data_s) begin
            tx_done    <= ack_ok_r;
            tx_error   <= ~ack_ok_r;
            tx_ready   <= 1'b1;
            rx_inhibit <= 1'b0;
            state_r    <= S_IDLE;
          end
        end
        default: begin
          kbd_clk_oe  <= 1'b0;
          kbd_data_oe <= 1'b0;
          tx_ready    <= 1'b1;
          rx_inhibit  <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Device-silence watchdog, restarted by every accepted falling edge.
      if (state_r == S_RELEASE || state_r == S_SHIFT || state_r == S_ACK) begin
        if (fall_s) begin
          to_cnt_r <= '0;
        end else if (to_cnt_r == TO_LAST) begin
          to_cnt_r    <= '0;
          kbd_clk_oe  <= 1'b0;
          kbd_data_oe <= 1'b0;
          tx_error    <= 1'b1;
          tx_ready    <= 1'b1;
          rx_inhibit  <= 1'b0;
          state_r     <= S_IDLE;
        end else begin
          to_cnt_r <= to_cnt_r + TO_W'(1);
        end
      end else begin
        to_cnt_r <= '0;
      end
`endif
    end
  end

endmodule
